eth_pcs_rx_link_ctrl: RTL and testbench
=======================================

Name: eth_pcs_rx_link_ctrl

Overview:
- Receive-side link controller for the 10GBASE-R PCS.
- Sits after the RX block-sync unit and before the descrambler/decoder status path.
- Rate-limits slip requests from block sync toward the RX gearbox and runs the Clause 49 BER monitor (hi_ber over a 125 us window).
- Sequences a link-state machine that produces the qualified rx_status, and keeps a 6-bit saturating BER counter for management.

Parameters:
- W_SYNC, 2, sync header width; valid headers are 2'b01 (data) and 2'b10 (ctrl).
- BER_WINDOW, 19531, BER window length in i_clk cycles (125 us at 156.25 MHz).
- BER_TH, 16, invalid headers within one window that assert hi_ber.
- SLIP_WAIT, 4, valid cycles after a forwarded slip during which further slip requests are dropped.
- LINK_UP_WAIT, 1024, consecutive clean clock cycles in WAIT before the link is declared UP.

Ports:
- i_clk  in  1  core clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  gearbox block-valid qualifier.
- i_sync_hdr  in  W_SYNC  sync header of current block.
- i_rx_lock  in  1  block_lock from block sync.
- i_slip_req  in  1  slip request pulse from block sync.
- i_ber_cnt_clr  in  1  clear-on-read strobe for o_ber_cnt.
- o_gb_slip  out  1  single-cycle slip pulse to gearbox.
- o_hi_ber  out  1  high bit-error-rate flag.
- o_rx_status  out  1  qualified link-up (1 only in state UP).
- o_link_state  out  2  DOWN=0, WAIT=1, UP=2, HI_BER=3.
- o_ber_cnt  out  6  saturating count of invalid headers while locked.

Behaviour:
- Reset values: all outputs 0, state DOWN, all counters 0, slip hold-off idle. Reset may assert in any cycle and takes effect immediately.
- Header invalid: i_valid=1, i_rx_lock=1, and i_sync_hdr not 01/10. Headers with i_valid=0 are ignored entirely.
- Slip gating:
  - When i_slip_req=1, i_valid=1 and hold-off is idle: o_gb_slip=1 on the next cycle for exactly one cycle (registered, latency 1), and the hold-off counter loads SLIP_WAIT.
  - The hold-off counter decrements on i_valid cycles only.
  - Requests arriving while the counter is nonzero are dropped, not queued.
- BER window timer:
  - Counts i_clk cycles 0..BER_WINDOW-1 while i_rx_lock=1.
  - Forced to 0 while i_rx_lock=0 and restarts on the lock rising edge.
  - Wraps to 0 after BER_WINDOW-1.
- Window error count ber_win:
  - Width clog2(BER_TH+1); increments on an invalid header and saturates at BER_TH.
  - o_hi_ber sets on the cycle after ber_win reaches BER_TH.
  - At wrap: if ber_win<BER_TH, o_hi_ber clears; in either case ber_win resets to 0.
  - If an invalid header coincides with the wrap, it counts into the new window (ber_win=1).
  - While i_rx_lock=0: o_hi_ber=0 and ber_win=0.
- o_ber_cnt:
  - Increments on every invalid header and saturates at 63.
  - i_ber_cnt_clr clears it to 0. If clear and increment coincide, the result is 1.
- Link FSM (registered; o_rx_status and o_link_state follow the state register):
  - DOWN -> WAIT when i_rx_lock=1.
  - WAIT: up-counter increments per cycle while o_hi_ber=0. It resets to 0 on entry and whenever o_hi_ber=1. When it reaches LINK_UP_WAIT-1, the FSM goes to UP.
  - UP -> HI_BER when o_hi_ber=1.
  - HI_BER -> WAIT when o_hi_ber=0.
  - Any state -> DOWN when i_rx_lock=0; this has priority over every other transition.
- o_rx_status=1 only in UP, and drops the cycle after leaving UP.

Test Plan:
- Bench params: BER_WINDOW=64, BER_TH=16, SLIP_WAIT=4, LINK_UP_WAIT=8.
- Reset, then i_rx_lock=1 with all headers 01 -> state WAIT, then UP 8 cycles later; o_rx_status=1, o_hi_ber=0, o_ber_cnt=0.
- Three i_slip_req pulses on consecutive valid cycles -> exactly one o_gb_slip pulse; a request on the 5th valid cycle after the first -> a second pulse.
- In UP, inject 16 invalid headers (00/11) within one window -> o_hi_ber=1, state HI_BER, o_rx_status=0. Next window with 15 errors -> o_hi_ber clears at wrap, state WAIT, then UP after 8 clean cycles.
- Inject 70 invalid headers while locked -> o_ber_cnt saturates at 63. Clear strobe coincident with an error -> o_ber_cnt=1.
- Drop i_rx_lock while in HI_BER -> state DOWN next cycle, o_hi_ber=0, timer=0. Invalid headers with i_valid=0 leave all counters unchanged.
- Assert i_reset mid-window while in UP with ber_win=10 -> all outputs 0 immediately (asynchronous); after release, state DOWN.

Source files
------------

// File: rtl/eth_pcs_rx_link_ctrl.sv
// 10GBASE-R RX link controller: slip rate limiting, hi_ber window monitor, link-state FSM.
// All outputs registered (1-cycle latency); no backpressure, slip requests during hold-off are dropped.
module eth_pcs_rx_link_ctrl #(
  parameter int W_SYNC       = 2,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_TH       = 16,
  parameter int SLIP_WAIT    = 4,
  parameter int LINK_UP_WAIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [W_SYNC-1:0] i_sync_hdr,
  input  logic              i_rx_lock,
  input  logic              i_slip_req,
  input  logic              i_ber_cnt_clr,
  output logic              o_gb_slip,
  output logic              o_hi_ber,
  output logic              o_rx_status,
  output logic [1:0]        o_link_state,
  output logic [5:0]        o_ber_cnt
);

  localparam int TMR_W  = (BER_WINDOW > 2) ? $clog2(BER_WINDOW) : 1;
  localparam int WIN_W  = $clog2(BER_TH + 1);
  localparam int HOLD_W = $clog2(SLIP_WAIT + 1);
  localparam int UP_W   = (LINK_UP_WAIT > 2) ? $clog2(LINK_UP_WAIT) : 1;

  localparam logic [W_SYNC-1:0] HDR_DATA  = W_SYNC'(1);
  localparam logic [W_SYNC-1:0] HDR_CTRL  = W_SYNC'(2);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(BER_WINDOW - 1);
  localparam logic [WIN_W-1:0]  WIN_TH    = WIN_W'(BER_TH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SLIP_WAIT);
  localparam logic [UP_W-1:0]   UP_LAST   = UP_W'(LINK_UP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UP     = 2'd2,
    ST_HI_BER = 2'd3
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   slip_hold;
  logic [TMR_W-1:0]    ber_timer;
  logic [WIN_W-1:0]    ber_win;
  logic [UP_W-1:0]     up_cnt;
  logic                hdr_bad;

  assign hdr_bad      = i_valid && i_rx_lock && (i_sync_hdr != HDR_DATA) && (i_sync_hdr != HDR_CTRL);
  assign o_link_state = state;

  // Hold-off only advances on valid blocks so the gearbox sees whole blocks between slips.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_gb_slip <= 1'b0;
      slip_hold <= '0;
    end else begin
      o_gb_slip <= 1'b0;
      if (i_valid) begin
        if (i_slip_req && (slip_hold == '0)) begin
          o_gb_slip <= 1'b1;
          slip_hold <= HOLD_LOAD;
        end else if (slip_hold != '0) begin
          slip_hold <= slip_hold - HOLD_W'(1);
        end
      end
    end
  end

  // An error landing on the wrap cycle belongs to the window that is just starting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ber_timer <= '0;
      ber_win   <= '0;
      o_hi_ber  <= 1'b0;
    end else if (!i_rx_lock) begin
      ber_timer <= '0;
      ber_win   <= '0;
      o_hi_ber  <= 1'b0;
    end else if (ber_timer == TMR_LAST) begin
      ber_timer <= '0;
      ber_win   <= hdr_bad ? WIN_W'(1) : '0;
      o_hi_ber  <= (ber_win == WIN_TH);
    end else begin
      ber_timer <= ber_timer + TMR_W'(1);
      if (hdr_bad && (ber_win != WIN_TH))
        ber_win <= ber_win + WIN_W'(1);
      if (ber_win == WIN_TH)
        o_hi_ber <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ber_cnt <= '0;
    end else if (i_ber_cnt_clr) begin
      o_ber_cnt <= {5'd0, hdr_bad};
    end else if (hdr_bad && (o_ber_cnt != 6'd63)) begin
      o_ber_cnt <= o_ber_cnt + 6'd1;
    end
  end

  // Loss of lock overrides every other transition.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_DOWN;
      up_cnt      <= '0;
      o_rx_status <= 1'b0;
    end else if (!i_rx_lock) begin
      state       <= ST_DOWN;
      up_cnt      <= '0;
      o_rx_status <= 1'b0;
    end else begin
      case (state)
        ST_DOWN: begin
          state       <= ST_WAIT;
          up_cnt      <= '0;
          o_rx_status <= 1'b0;
        end
        ST_WAIT: begin
          if (o_hi_ber) begin
            up_cnt <= '0;
          end else if (up_cnt == UP_LAST) begin
            state       <= ST_UP;
            o_rx_status <= 1'b1;
          end else begin
            up_cnt <= up_cnt + UP_W'(1);
          end
        end
        ST_UP: begin
          if (o_hi_ber) begin
            state       <= ST_HI_BER;
            o_rx_status <= 1'b0;
          end
        end
        ST_HI_BER: begin
          if (!o_hi_ber) begin
            state  <= ST_WAIT;
            up_cnt <= '0;
          end
        end
        default: begin
          state       <= ST_DOWN;
          up_cnt      <= '0;
          o_rx_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_link_ctrl.sv
// Bench for eth_pcs_rx_link_ctrl: directed steps with randomized headers, checked every cycle
// against a behavioural model built from window/run-length bookkeeping.
module tb_eth_pcs_rx_link_ctrl;
  localparam int BW  = 64;
  localparam int TH  = 16;
  localparam int SWT = 4;
  localparam int LUW = 8;

  logic       i_clk = 1'b0;
  logic       i_reset, i_valid, i_rx_lock, i_slip_req, i_ber_cnt_clr;
  logic [1:0] i_sync_hdr;
  logic       o_gb_slip, o_hi_ber, o_rx_status;
  logic [1:0] o_link_state;
  logic [5:0] o_ber_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: lock age in cycles, raw errors in current window, valid blocks since last slip.
  int m_age, m_win, m_vsince, m_cnt, m_st, m_clean;
  bit m_hi, m_gb;
  int pulses, cnt_save;
  int err_pct;

  eth_pcs_rx_link_ctrl #(
    .W_SYNC(2), .BER_WINDOW(BW), .BER_TH(TH), .SLIP_WAIT(SWT), .LINK_UP_WAIT(LUW)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_sync_hdr(i_sync_hdr),
    .i_rx_lock(i_rx_lock), .i_slip_req(i_slip_req), .i_ber_cnt_clr(i_ber_cnt_clr),
    .o_gb_slip(o_gb_slip), .o_hi_ber(o_hi_ber), .o_rx_status(o_rx_status),
    .o_link_state(o_link_state), .o_ber_cnt(o_ber_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_age = 0; m_win = 0; m_vsince = SWT; m_cnt = 0;
    m_st = 0; m_clean = 0; m_hi = 0; m_gb = 0;
  endtask

  task automatic model_edge();
    int bad, nst;
    bit nhi;
    if (i_reset) begin
      model_reset();
      return;
    end
    bad = (i_valid && i_rx_lock && (i_sync_hdr == 2'b00 || i_sync_hdr == 2'b11)) ? 1 : 0;
    m_gb = i_valid && i_slip_req && (m_vsince >= SWT);
    if (m_gb) m_vsince = 0;
    else if (i_valid) m_vsince++;
    nst = m_st;
    if (!i_rx_lock) begin
      nst = 0; m_clean = 0;
    end else if (m_st == 0) begin
      nst = 1; m_clean = 0;
    end else if (m_st == 1) begin
      if (m_hi) m_clean = 0;
      else begin
        m_clean++;
        if (m_clean == LUW) nst = 2;
      end
    end else if (m_st == 2) begin
      if (m_hi) nst = 3;
    end else if (!m_hi) begin
      nst = 1; m_clean = 0;
    end
    if (!i_rx_lock) begin
      m_age = 0; m_win = 0; nhi = 0;
    end else begin
      if (m_age % BW == BW - 1) begin
        nhi = (m_win >= TH);
        m_win = bad;
      end else begin
        nhi = m_hi || (m_win >= TH);
        m_win += bad;
      end
      m_age++;
    end
    m_cnt = i_ber_cnt_clr ? bad : ((m_cnt + bad > 63) ? 63 : m_cnt + bad);
    m_st = nst;
    m_hi = nhi;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("gb_slip",    {7'd0, o_gb_slip},    {7'd0, m_gb});
    chk("hi_ber",     {7'd0, o_hi_ber},     {7'd0, m_hi});
    chk("rx_status",  {7'd0, o_rx_status},  (m_st == 2) ? 8'd1 : 8'd0);
    chk("link_state", {6'd0, o_link_state}, 8'(m_st));
    chk("ber_cnt",    {2'd0, o_ber_cnt},    8'(m_cnt));
  endtask

  task automatic run_clean(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_sync_hdr = 2'($urandom_range(1, 2));
      cycle();
    end
  endtask

  task automatic run_err(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_sync_hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      cycle();
    end
  endtask

  task automatic wait_win_start();
    for (int k = 0; k < BW && (m_age % BW) != 0; k++) run_clean(1);
  endtask

  task automatic wait_up();
    for (int k = 0; k < 4 * BW && m_st != 2; k++) run_clean(1);
    chk("reach_up", {6'd0, o_link_state}, 8'd2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slip"},   {7'd0, o_gb_slip},    8'd0);
    chk({tag, "_hiber"},  {7'd0, o_hi_ber},     8'd0);
    chk({tag, "_status"}, {7'd0, o_rx_status},  8'd0);
    chk({tag, "_state"},  {6'd0, o_link_state}, 8'd0);
    chk({tag, "_cnt"},    {2'd0, o_ber_cnt},    8'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_sync_hdr = 2'b01; i_rx_lock = 1'b0;
    i_slip_req = 1'b0; i_ber_cnt_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (3) cycle();
    i_reset = 1'b0;

    // Lock up with clean headers: WAIT, then UP after the clean-run length.
    i_rx_lock = 1'b1;
    run_clean(1);
    chk("enter_wait", {6'd0, o_link_state}, 8'd1);
    run_clean(LUW);
    chk("up_state",  {6'd0, o_link_state}, 8'd2);
    chk("up_status", {7'd0, o_rx_status},  8'd1);
    chk("up_hiber",  {7'd0, o_hi_ber},     8'd0);
    chk("up_cnt",    {2'd0, o_ber_cnt},    8'd0);

    // Slip burst: only the first of three is forwarded; invalid cycles do not age the hold-off.
    pulses = 0;
    i_slip_req = 1'b1;
    for (int k = 0; k < 3; k++) begin run_clean(1); pulses += o_gb_slip; end
    i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin cycle(); pulses += o_gb_slip; end
    i_slip_req = 1'b0;
    for (int k = 0; k < 2; k++) begin run_clean(1); pulses += o_gb_slip; end
    chk("slip_burst_pulses", 8'(pulses), 8'd1);
    i_slip_req = 1'b1;
    run_clean(1);
    chk("slip_second", {7'd0, o_gb_slip}, 8'd1);
    i_slip_req = 1'b0;
    run_clean(1);
    chk("slip_one_cycle", {7'd0, o_gb_slip}, 8'd0);

    // Threshold window, then a window one error short clears hi_ber at the wrap.
    wait_win_start();
    run_err(TH);
    run_clean(2);
    chk("hiber_set",    {7'd0, o_hi_ber},     8'd1);
    chk("hiber_state",  {6'd0, o_link_state}, 8'd3);
    chk("hiber_status", {7'd0, o_rx_status},  8'd0);
    wait_win_start();
    chk("hiber_held", {7'd0, o_hi_ber}, 8'd1);
    run_err(TH - 1);
    wait_win_start();
    chk("hiber_clear", {7'd0, o_hi_ber}, 8'd0);
    run_clean(1);
    chk("back_to_wait", {6'd0, o_link_state}, 8'd1);
    run_clean(LUW);
    chk("back_to_up", {6'd0, o_link_state}, 8'd2);

    // Counter saturation and clear/increment collision.
    run_err(70);
    chk("cnt_sat", {2'd0, o_ber_cnt}, 8'd63);
    i_ber_cnt_clr = 1'b1;
    run_err(1);
    chk("clr_with_err", {2'd0, o_ber_cnt}, 8'd1);
    run_clean(1);
    chk("clr_alone", {2'd0, o_ber_cnt}, 8'd0);
    i_ber_cnt_clr = 1'b0;

    // Drop lock from HI_BER; then invalid-but-unqualified blocks must leave counters alone.
    wait_up();
    wait_win_start();
    run_err(TH);
    run_clean(2);
    chk("pre_drop_state", {6'd0, o_link_state}, 8'd3);
    cnt_save = m_cnt;
    i_rx_lock = 1'b0;
    run_err(1);
    chk("drop_state", {6'd0, o_link_state}, 8'd0);
    chk("drop_hiber", {7'd0, o_hi_ber},     8'd0);
    i_rx_lock = 1'b1;
    i_valid = 1'b0;
    i_slip_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_sync_hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      cycle();
      chk("novalid_cnt",  {2'd0, o_ber_cnt}, 8'(cnt_save));
      chk("novalid_slip", {7'd0, o_gb_slip}, 8'd0);
    end
    i_slip_req = 1'b0;

    // Asynchronous reset mid-window while UP with ten window errors.
    wait_up();
    wait_win_start();
    run_clean(5);
    run_err(10);
    run_clean(3);
    #2;
    i_reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    cycle();
    i_reset = 1'b0;
    #1;
    chk("post_rst_state", {6'd0, o_link_state}, 8'd0);

    // Randomized traffic across segments of differing error density.
    for (int seg = 0; seg < 8; seg++) begin
      err_pct = (seg % 4 == 0) ? 0 : (seg % 4 == 1) ? 20 : (seg % 4 == 2) ? 30 : 50;
      for (int k = 0; k < 200; k++) begin
        i_valid       = ($urandom_range(0, 7) != 0);
        i_sync_hdr    = ($urandom_range(0, 99) < err_pct) ?
                        (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11) : 2'($urandom_range(1, 2));
        i_slip_req    = ($urandom_range(0, 4) == 0);
        i_ber_cnt_clr = ($urandom_range(0, 19) == 0);
        i_rx_lock     = ($urandom_range(0, 249) != 0);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
